// File: rtl/echo_capture_if.sv
// Line-buffer write bus and per-window range report driven by echo_capture.
interface echo_capture_if #(
  parameter int BIN_W = 5,
  parameter int CNT_W = 7
);
  logic               wr_en;
  logic [8+BIN_W-1:0] wr_addr;
  logic [CNT_W-1:0]   wr_data;
  logic               range_valid;
  logic               range_hit;
  logic [BIN_W-1:0]   range_bin;
  logic               busy;

  modport master (output wr_en, wr_addr, wr_data, range_valid, range_hit, range_bin, busy);
  modport slave  (input  wr_en, wr_addr, wr_data, range_valid, range_hit, range_bin, busy);
endinterface

// File: rtl/echo_capture.sv
// Bins synchronized echo-high cycles into range bins during a receive window,
// writes each bin to the line buffer and reports the first qualifying bin.
module echo_capture #(
  parameter int BIN_CYCLES = 65,
  parameter int NUM_BINS   = 31,
  parameter int BIN_W      = 5,
  parameter int CNT_W      = 7,
  parameter int BLANK_BINS = 1,
  parameter int THRESH     = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         receive,
  input  logic         echo,
  input  logic [7:0]   angle,
  echo_capture_if.master cap
);
  localparam int CYC_W = $clog2(BIN_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic               sync1_q, echo_s_q;
  logic               rcv_q;
  logic [1:0]         state_q, state_d;
  logic [7:0]         angle_q, angle_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [BIN_W-1:0]   fbin_q, fbin_d;
  logic               pend_q, pend_d;
  logic               wr_en_q, wr_en_d;
  logic [8+BIN_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]   wr_data_q, wr_data_d;
  logic               rv_q, rv_d;
  logic               hit_q, hit_d;
  logic [BIN_W-1:0]   rbin_q, rbin_d;

  logic               rise;
  logic [CNT_W-1:0]   cnt_sum;
  logic               do_wr;
  logic [CNT_W-1:0]   wr_cnt;

  assign rise    = receive & ~rcv_q;
  assign cnt_sum = cnt_q + {{(CNT_W-1){1'b0}}, echo_s_q};

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    bin_d     = bin_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    fbin_d    = fbin_q;
    pend_d    = pend_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rv_d      = 1'b0;
    hit_d     = hit_q;
    rbin_d    = rbin_q;
    do_wr     = 1'b0;
    wr_cnt    = cnt_q;

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        // The start cycle is window cycle 0 and is already counted.
        if (rise || (pend_q && receive)) begin
          state_d = S_ACQ;
          angle_d = angle;
          bin_d   = '0;
          cyc_d   = CYC_W'(1);
          cnt_d   = {{(CNT_W-1){1'b0}}, echo_s_q};
          found_d = 1'b0;
          fbin_d  = '0;
        end
      end
      S_ACQ: begin
        if (!receive) begin
          if (cyc_q != '0) begin
            do_wr  = 1'b1;
            wr_cnt = cnt_q;
          end
          state_d = S_DONE;
        end else if (cyc_q == CYC_W'(BIN_CYCLES-1)) begin
          do_wr  = 1'b1;
          wr_cnt = cnt_sum;
          cnt_d  = '0;
          cyc_d  = '0;
          if (bin_q == BIN_W'(NUM_BINS-1)) state_d = S_OVER;
          else                             bin_d   = bin_q + BIN_W'(1);
        end else begin
          cnt_d = cnt_sum;
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_OVER: begin
        if (!receive) state_d = S_DONE;
      end
      default: begin
        rv_d    = 1'b1;
        hit_d   = found_q;
        rbin_d  = fbin_q;
        pend_d  = rise;
        state_d = S_IDLE;
      end
    endcase

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {angle_q, bin_q};
      wr_data_d = wr_cnt;
      if (!found_q && (bin_q >= BIN_W'(BLANK_BINS)) && (wr_cnt >= CNT_W'(THRESH))) begin
        found_d = 1'b1;
        fbin_d  = bin_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      echo_s_q  <= 1'b0;
      // Treat receive as already high so a window cut by reset is not restarted.
      rcv_q     <= 1'b1;
      state_q   <= S_IDLE;
      angle_q   <= '0;
      bin_q     <= '0;
      cyc_q     <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      fbin_q    <= '0;
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rv_q      <= 1'b0;
      hit_q     <= 1'b0;
      rbin_q    <= '0;
    end else begin
      sync1_q   <= echo;
      echo_s_q  <= sync1_q;
      rcv_q     <= receive;
      state_q   <= state_d;
      angle_q   <= angle_d;
      bin_q     <= bin_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      fbin_q    <= fbin_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rv_q      <= rv_d;
      hit_q     <= hit_d;
      rbin_q    <= rbin_d;
    end
  end

  assign cap.wr_en       = wr_en_q;
  assign cap.wr_addr     = wr_addr_q;
  assign cap.wr_data     = wr_data_q;
  assign cap.range_valid = rv_q;
  assign cap.range_hit   = hit_q;
  assign cap.range_bin   = rbin_q;
  assign cap.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_echo_capture.sv
// Directed bench for echo_capture: window scenarios with hand-computed bins.
module tb_echo_capture;
  localparam int BIN_W = 5;
  localparam int CNT_W = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       receive = 1'b0;
  logic       echo = 1'b0;
  logic [7:0] angle = 8'd0;

  echo_capture_if #(.BIN_W(BIN_W), .CNT_W(CNT_W)) cap ();

  echo_capture #(
    .BIN_CYCLES(65), .NUM_BINS(31), .BIN_W(BIN_W), .CNT_W(CNT_W),
    .BLANK_BINS(1), .THRESH(16)
  ) dut (
    .clock(clock), .reset(reset), .receive(receive), .echo(echo),
    .angle(angle), .cap(cap)
  );

  always #5 clock = ~clock;

  int pc = 0;
  always @(posedge clock) pc <= pc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int wa[$]; int wd[$]; int wc[$];
  int rvc[$]; int rvh[$]; int rvb[$];

  always @(negedge clock) begin
    if (cap.wr_en) begin
      wa.push_back(int'(cap.wr_addr));
      wd.push_back(int'(cap.wr_data));
      wc.push_back(pc);
    end
    if (cap.range_valid) begin
      rvc.push_back(pc);
      rvh.push_back(int'(cap.range_hit));
      rvb.push_back(int'(cap.range_bin));
    end
  end

  logic pat [4096];
  int   expd [31];
  int   t0;
  int   tf;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
    rvc.delete(); rvh.delete(); rvb.delete();
    for (int i = 0; i < 4096; i++) pat[i] = 1'b0;
    for (int i = 0; i < 31; i++) expd[i] = 0;
  endtask

  // Pin value on window cycle j is pat[j]; pre covers cycles -2 and -1.
  task automatic run_window(input int len, input logic [7:0] ang, input logic pre);
    receive = 1'b0; echo = pre; angle = ang;
    repeat (3) tick();
    for (int j = 0; j < len; j++) begin
      receive = 1'b1; echo = pat[j];
      tick();
      if (j == 0) t0 = pc;
    end
    receive = 1'b0; echo = 1'b0;
    repeat (5) tick();
  endtask

  task automatic check_writes(input string tag, input int n, input int ang);
    chk({tag, ".nwr"}, wa.size(), n);
    for (int b = 0; b < n; b++) begin
      if (b < wa.size()) begin
        chk($sformatf("%s.addr%0d", tag, b), wa[b], ang * 32 + b);
        chk($sformatf("%s.data%0d", tag, b), wd[b], expd[b]);
      end
    end
  endtask

  task automatic check_range(input string tag, input int hit, input int bin);
    chk({tag, ".nrv"}, rvc.size(), 1);
    if (rvc.size() > 0) begin
      chk({tag, ".hit"}, rvh[0], hit);
      chk({tag, ".bin"}, rvb[0], bin);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, ".wr_en"},   cap.wr_en, 0);
    chk({tag, ".wr_addr"}, cap.wr_addr, 0);
    chk({tag, ".wr_data"}, cap.wr_data, 0);
    chk({tag, ".rv"},      cap.range_valid, 0);
    chk({tag, ".hit"},     cap.range_hit, 0);
    chk({tag, ".bin"},     cap.range_bin, 0);
    chk({tag, ".busy"},    cap.busy, 0);
  endtask

  initial begin
    clr();
    repeat (3) tick();
    check_idle_outs("rst");
    reset = 1'b0;
    tick();

    // Quiet 2000-cycle window: 30 full bins plus partial bin 30.
    clr();
    run_window(2000, 8'd20, 1'b0);
    check_writes("quiet", 31, 20);
    if (wc.size() == 31) begin
      chk("quiet.lat0",  wc[0],  t0 + 64);
      chk("quiet.lat30", wc[30], t0 + 2000);
    end
    check_range("quiet", 0, 0);
    if (rvc.size() > 0) chk("quiet.rvlat", rvc[0], t0 + 2001);

    // Echo pin high on cycles 648..712 lands entirely in bin 10.
    clr();
    for (int j = 648; j <= 712; j++) pat[j] = 1'b1;
    expd[10] = 65;
    run_window(2000, 8'd21, 1'b0);
    check_writes("bin10", 31, 21);
    check_range("bin10", 1, 10);

    // Blanked bin 0, bin 3 below threshold, bin 5 exactly at threshold.
    clr();
    for (int j = 0; j <= 62; j++) pat[j] = 1'b1;
    for (int j = 193; j <= 207; j++) pat[j] = 1'b1;
    for (int j = 323; j <= 338; j++) pat[j] = 1'b1;
    expd[0] = 65; expd[3] = 15; expd[5] = 16;
    run_window(400, 8'd5, 1'b1);
    check_writes("thr", 7, 5);
    check_range("thr", 1, 5);

    // Long window: exactly 31 writes, overflow stays silent until receive falls.
    clr();
    for (int j = 0; j < 4000; j++) pat[j] = 1'b1;
    for (int b = 0; b < 31; b++) expd[b] = 65;
    run_window(4000, 8'd200, 1'b1);
    check_writes("long", 31, 200);
    if (wc.size() == 31) chk("long.lat30", wc[30], t0 + 2014);
    check_range("long", 1, 1);
    if (rvc.size() > 0) chk("long.rvlat", rvc[0], t0 + 4001);

    // Reset at window cycle 700 aborts the window.
    clr();
    receive = 1'b0; echo = 1'b0; angle = 8'd33;
    repeat (3) tick();
    for (int j = 0; j < 1000; j++) begin
      receive = 1'b1;
      echo = (j < 900);
      if (j == 700) reset = 1'b1;
      tick();
      if (j == 700) begin
        reset = 1'b0;
        check_idle_outs("rstmid");
        chk("rstmid.nwr_pre", wa.size(), 10);
      end
    end
    receive = 1'b0; echo = 1'b0;
    repeat (5) tick();
    chk("rstmid.nwr_post", wa.size(), 10);
    chk("rstmid.nrv", rvc.size(), 0);

    clr();
    run_window(100, 8'd44, 1'b0);
    check_writes("after", 2, 44);
    check_range("after", 0, 0);

    // Receive rises during DONE: first window still reports, second starts next cycle.
    clr();
    receive = 1'b0; echo = 1'b0; angle = 8'd7;
    repeat (3) tick();
    for (int j = 0; j < 10; j++) begin
      receive = 1'b1;
      tick();
    end
    receive = 1'b0;
    tick();
    tf = pc;
    receive = 1'b1; angle = 8'd8;
    tick();
    repeat (79) tick();
    receive = 1'b0;
    repeat (5) tick();
    chk("hold.nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("hold.a0",  wa[0], 7 * 32);
      chk("hold.c0",  wc[0], tf);
      chk("hold.a1",  wa[1], 8 * 32);
      chk("hold.c1",  wc[1], tf + 66);
      chk("hold.a2",  wa[2], 8 * 32 + 1);
      chk("hold.c2",  wc[2], tf + 81);
    end
    chk("hold.nrv", rvc.size(), 2);
    if (rvc.size() > 0) chk("hold.rv0", rvc[0], tf + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
